// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg: shared types and constants for the arbitrated fixed-point multiplier.
//   q31_32_t    : signed Q31.32 value (1 sign bit, 31 integer bits, 32 fraction bits)
//   Q_FRAC_BITS : number of fraction bits in q31_32_t
//   Q_ZERO      : the canonical zero value
package mult_arb_pkg;

    typedef logic signed [63:0] q31_32_t;

    localparam int unsigned Q_FRAC_BITS = 32;
    localparam q31_32_t     Q_ZERO      = 64'd0;

endpackage

// File: rtl/mult_arbiter_fixmul.sv
// fixmul_q31_32: combinational signed Q31.32 multiplier.
// Sign-magnitude product truncated toward zero; overflow wraps silently.
//   a : operand A, signed Q31.32
//   b : operand B, signed Q31.32
//   c : product,   signed Q31.32
module fixmul_q31_32
    import mult_arb_pkg::*;
(
    input  q31_32_t a,
    input  q31_32_t b,
    output q31_32_t c
);

    logic [63:0]  mag_a;
    logic [63:0]  mag_b;
    logic [127:0] prod;
    logic [63:0]  mag_c;
    logic         neg;
    logic         prod_unused;

    always_comb begin
        // The most negative input maps to 2^63, which still fits the unsigned magnitude.
        mag_a = a[63] ? (~a + 64'd1) : a;
        mag_b = b[63] ? (~b + 64'd1) : b;
        prod  = {64'd0, mag_a} * {64'd0, mag_b};
        mag_c = prod[Q_FRAC_BITS +: 64];
        neg   = a[63] ^ b[63];
        // A zero magnitude must not be negated, so zero never carries a sign.
        if (mag_c == 64'd0) begin
            c = Q_ZERO;
        end else if (neg) begin
            c = ~mag_c + 64'd1;
        end else begin
            c = mag_c;
        end
    end

    // Integer overflow bits and discarded fraction bits.
    assign prod_unused = ^{prod[127:96], prod[31:0]};

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: N_REQ requesters share one two-stage Q31.32 multiplier pipeline.
//   S1 holds the granted operands and requester id, S2 holds the product and id.
//   Both stages hold while the result register is full and not being accepted.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   req_valid/ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_b       : per-requester Q31.32 operands, requester 0 in bits 63:0
//   rsp_valid/ready    : result handshake
//   rsp_data, rsp_id   : product and owning requester, straight from S2 registers
//   op_count           : number of accepted results, wraps at 16 bits
// Build option: define MULT_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins,
// no round-robin pointer); otherwise round-robin starting from rr_ptr.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int ID_W  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*64-1:0]  req_a,
    input  logic [N_REQ*64-1:0]  req_b,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [ID_W-1:0]      rsp_id,
    output logic [15:0]          op_count
);

    logic             advance;
    logic [N_REQ-1:0] grant_oh;
    logic             grant_any;
    logic [ID_W-1:0]  grant_id;
    q31_32_t          sel_a;
    q31_32_t          sel_b;

    logic             s1_valid;
    q31_32_t          s1_a;
    q31_32_t          s1_b;
    logic [ID_W-1:0]  s1_id;
    q31_32_t          s1_prod;

    logic             s2_valid;
    q31_32_t          s2_data;
    logic [ID_W-1:0]  s2_id;

    assign advance = !s2_valid || rsp_ready;

`ifdef MULT_ARB_FIXED_PRIO_EN
    always_comb begin
        grant_oh  = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i]) begin
                grant_any   = 1'b1;
                grant_id    = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
    end
`else
    logic [ID_W-1:0] rr_ptr;

    // Two passes give the wrapped search order: rr_ptr..N_REQ-1, then 0..rr_ptr-1.
    always_comb begin
        grant_oh  = '0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i] && (i >= int'(rr_ptr))) begin
                grant_any   = 1'b1;
                grant_id    = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_any && req_valid[i] && (i < int'(rr_ptr))) begin
                grant_any   = 1'b1;
                grant_id    = ID_W'(i);
                grant_oh[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (advance && grant_any) begin
            if (grant_id == ID_W'(N_REQ - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_id + 1'b1;
            end
        end
    end
`endif

    // advance is high during reset (S2 empty), so ready is forced low explicitly.
    assign req_ready = (advance && rst_n) ? grant_oh : '0;

    // One-hot operand mux.
    always_comb begin
        sel_a = Q_ZERO;
        sel_b = Q_ZERO;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_oh[i]) begin
                sel_a = req_a[i*64 +: 64];
                sel_b = req_b[i*64 +: 64];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= Q_ZERO;
            s1_b     <= Q_ZERO;
            s1_id    <= '0;
        end else if (advance) begin
            s1_valid <= grant_any;
            if (grant_any) begin
                s1_a  <= sel_a;
                s1_b  <= sel_b;
                s1_id <= grant_id;
            end
        end
    end

    fixmul_q31_32 u_fixmul (
        .a (s1_a),
        .b (s1_b),
        .c (s1_prod)
    );

    // S2 payload only loads with a valid S1, keeping rsp_data quiet across bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= Q_ZERO;
            s2_id    <= '0;
        end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= s1_prod;
                s2_id   <= s1_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= 16'd0;
        end else if (s2_valid && rsp_ready) begin
            op_count <= op_count + 16'd1;
        end
    end

    assign rsp_valid = s2_valid;
    assign rsp_data  = s2_data;
    assign rsp_id    = s2_id;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: directed self-checking bench for mult_arbiter with a result scoreboard.
// Honours MULT_ARB_FIXED_PRIO_EN for the expected grant order.
module tb_mult_arbiter;

    localparam int N_REQ = 3;
    localparam int ID_W  = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ*64-1:0] req_a;
    logic [N_REQ*64-1:0] req_b;
    logic [N_REQ-1:0]    req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [63:0]         rsp_data;
    logic [ID_W-1:0]     rsp_id;
    logic [15:0]         op_count;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [63:0]     data;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   acc_cnt = 0;
    int   hs_cnt  = 0;

    mult_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    // Reference: full signed product, scaled down by 2^32 rounding toward zero.
    function automatic logic [63:0] model_mul(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] fa;
        logic signed [127:0] fb;
        logic signed [127:0] full;
        logic signed [127:0] mag;
        fa   = {{64{a[63]}}, a};
        fb   = {{64{b[63]}}, b};
        full = fa * fb;
        if (full < 0) begin
            mag  = -full;
            mag  = mag >>> 32;
            full = -mag;
        end else begin
            full = full >>> 32;
        end
        return full[63:0];
    endfunction

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [63:0] a, input logic [63:0] b);
        req_a[i*64 +: 64] = a;
        req_b[i*64 +: 64] = b;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            step();
            n++;
        end
        check64(tag, 64'(sb.size()), 64'd0);
    endtask

    // Single request on requester 0 with directed latency and value checks.
    task automatic single(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp);
        set_req(0, a, b);
        req_valid = 3'b001;
        #1;
        check64({tag, "_ready"}, 64'(req_ready), 64'h1);
        step();
        req_valid = 3'b000;
        check64({tag, "_lat1"}, 64'(rsp_valid), 64'd0);
        step();
        check64({tag, "_valid"}, 64'(rsp_valid), 64'd1);
        check64({tag, "_data"}, rsp_data, exp);
        check64({tag, "_id"}, 64'(rsp_id), 64'd0);
    endtask

    // Scoreboard monitor, sampling mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            acc_cnt = 0;
        end else begin
            check64("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            if (rsp_valid && rsp_ready) begin
                check64("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check64("sb_id", 64'(rsp_id), 64'(e.id));
                    check64("sb_data", rsp_data, e.data);
                end
                acc_cnt++;
            end
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back({ID_W'(i), model_mul(req_a[i*64 +: 64], req_b[i*64 +: 64])});
                    hs_cnt++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N_REQ-1:0] exp_gnt;
        logic [63:0]      a0;
        logic [63:0]      b0;
        int               acc0;
        int               hs0;
        int               n;

        rst_n     = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        #12;
        check64("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check64("rst_rsp_data", rsp_data, 64'd0);
        check64("rst_rsp_id", 64'(rsp_id), 64'd0);
        check64("rst_op_count", 64'(op_count), 64'd0);
        check64("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        step();
        rst_n = 1'b1;
        step();

        // Directed products.
        single("mul_2x-3", 64'h0000_0002_0000_0000, 64'hFFFF_FFFD_0000_0000,
               64'hFFFF_FFFA_0000_0000);
        single("mul_0x-1", 64'h0, 64'hFFFF_FFFF_0000_0000, 64'h0);
        single("mul_half", 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
               64'h0000_0000_4000_0000);
        single("mul_negneg", 64'hFFFF_FFFE_8000_0000, 64'hFFFF_FFFE_0000_0000,
               64'h0000_0003_0000_0000);
        single("mul_negzero", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_8000_0000, 64'h0);
        step();
        check64("count_after_singles", 64'(op_count), 64'(acc_cnt));

        // Arbitration with all requesters valid, starting from reset.
        apply_reset();
        for (int i = 0; i < N_REQ; i++) begin
            set_req(i, 64'(i + 1) << 32, 64'(i + 5) << 31);
        end
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
`ifdef MULT_ARB_FIXED_PRIO_EN
            exp_gnt = 3'b001;
`else
            exp_gnt = 3'b001 << (k % 3);
`endif
            check64("rr_grant", 64'(req_ready), 64'(exp_gnt));
            if (k >= 2) begin
                check64("rr_rsp_each_cycle", 64'(rsp_valid), 64'd1);
            end
            step();
        end
        req_valid = 3'b000;
        drain("rr_drain");

        // Backpressure with two products in flight.
        a0 = 64'h0000_0003_4000_0000;
        b0 = 64'hFFFF_FFFF_8000_0000;
        set_req(0, a0, b0);
        set_req(1, 64'h0000_0007_0000_0000, 64'h0000_0000_1000_0000);
        rsp_ready = 1'b0;
        acc0      = acc_cnt;
        hs0       = hs_cnt;
        req_valid = 3'b011;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            check64("bp_valid", 64'(rsp_valid), 64'd1);
            check64("bp_data", rsp_data, model_mul(a0, b0));
            check64("bp_id", 64'(rsp_id), 64'd0);
            check64("bp_ready", 64'(req_ready), 64'd0);
            step();
        end
        req_valid = 3'b000;
        rsp_ready = 1'b1;
        drain("bp_drain");
        check64("bp_handshakes", 64'(hs_cnt - hs0), 64'd2);
        check64("bp_accepts", 64'(acc_cnt - acc0), 64'd2);
        check64("bp_count", 64'(op_count), 64'(acc_cnt));

        // Reset while a product sits in S2.
        set_req(2, 64'h0000_0001_0000_0000, 64'h0000_0009_0000_0000);
        rsp_ready = 1'b0;
        req_valid = 3'b100;
        step();
        req_valid = 3'b000;
        step();
        check64("mid_valid_before", 64'(rsp_valid), 64'd1);
        req_valid = 3'b111;
        rst_n     = 1'b0;
        #1;
        check64("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check64("mid_rsp_data", rsp_data, 64'd0);
        check64("mid_rsp_id", 64'(rsp_id), 64'd0);
        check64("mid_op_count", 64'(op_count), 64'd0);
        check64("mid_req_ready", 64'(req_ready), 64'd0);
        step();
        step();
        req_valid = 3'b000;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check64("mid_no_rsp", 64'(rsp_valid), 64'd0);
        end

        // op_count wrap after 65535 accepted results.
        req_valid = 3'b001;
        n = 0;
        while (acc_cnt < 65535 && n < 70000) begin
            set_req(0, {$urandom, $urandom}, {$urandom, $urandom});
            step();
            n++;
        end
        req_valid = 3'b000;
        rsp_ready = 1'b0;
        check64("wrap_reached", 64'(acc_cnt), 64'd65535);
        check64("wrap_preload", 64'(op_count), 64'hFFFF);
        check64("wrap_full", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        step();
        check64("wrap_zero", 64'(op_count), 64'd0);
        drain("wrap_drain");
        check64("wrap_final", 64'(op_count), 64'(acc_cnt & 32'hFFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
